// File: rtl/instr_queue_if.sv
// -----------------------------------------------------------------------------
// instr_queue_if
//   Bundles the fetcher-side push port, the decoder-side pop port and the
//   global rdy/flush controls of the instruction queue.
//
//   Modports:
//     master : the surrounding pipeline (fetcher + decoder + control). It drives
//              rdy, flush, valid/pc/instr from the fetcher and pop from the
//              decoder, and observes full, is_empty and the head pc/instr.
//     slave  : the instruction queue itself.
//
//   Parameters:
//     PC_W    : pc width
//     INSTR_W : instruction word width
// -----------------------------------------------------------------------------
interface instr_queue_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);

  // Global controls
  logic               rdy;
  logic               flush;

  // Fetcher side
  logic               valid_from_fetcher;
  logic [PC_W-1:0]    pc_from_fetcher;
  logic [INSTR_W-1:0] instr_from_fetcher;
  logic               full_to_fetcher;

  // Decoder side
  logic               pop_from_decoder;
  logic               is_empty_to_decoder;
  logic [PC_W-1:0]    pc_to_decoder;
  logic [INSTR_W-1:0] instr_to_decoder;

  modport master (
    output rdy,
    output flush,
    output valid_from_fetcher,
    output pc_from_fetcher,
    output instr_from_fetcher,
    output pop_from_decoder,
    input  full_to_fetcher,
    input  is_empty_to_decoder,
    input  pc_to_decoder,
    input  instr_to_decoder
  );

  modport slave (
    input  rdy,
    input  flush,
    input  valid_from_fetcher,
    input  pc_from_fetcher,
    input  instr_from_fetcher,
    input  pop_from_decoder,
    output full_to_fetcher,
    output is_empty_to_decoder,
    output pc_to_decoder,
    output instr_to_decoder
  );

endinterface

// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//   Circular FIFO between the instruction fetcher and the decoder. Holds
//   (pc, instr) pairs and presents the oldest entry first-word-fall-through.
//   The whole queue is discarded on flush (mispredict / jump redirect).
//
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous, active-high reset (clears pointers and count)
//     bus : instr_queue_if.slave
//             rdy                 - 0 freezes all state
//             flush               - discard every entry
//             valid_from_fetcher  - push request with pc/instr_from_fetcher
//             full_to_fetcher     - queue full, push is dropped
//             pop_from_decoder    - decoder consumes the head
//             is_empty_to_decoder - no valid head
//             pc/instr_to_decoder - head entry (zero when empty)
//
//   Parameters:
//     DEPTH_LOG2 : log2 of the entry count
//     PC_W       : pc width
//     INSTR_W    : instruction word width
//
//   Build option:
//     IQ_BYPASS_EN : when defined, a push into an empty queue is forwarded to
//                    the decoder outputs in the same cycle; if the decoder pops
//                    it right away the entry is never written.
// -----------------------------------------------------------------------------
module instr_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  instr_queue_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;
  logic bypass_hit;   // fetcher inputs are driving the decoder outputs
  logic bypass_take;  // ... and the decoder consumes them this cycle

  assign empty = (count_q == '0);
  assign full  = (count_q == cnt_t'(DEPTH));

`ifdef IQ_BYPASS_EN
  assign bypass_hit = empty & bus.valid_from_fetcher & bus.rdy & ~bus.flush;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit & bus.pop_from_decoder;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the if/else tree can leave one unassigned and infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push_ok = 1'b0;
    pop_ok  = 1'b0;

    if (bus.rdy) begin
      if (bus.flush) begin
        // Redirect: everything in flight is stale, including this cycle's
        // push and pop.
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        // A full queue drops the push even when a pop frees a slot in the
        // same cycle; the fetcher holds and retries. A bypassed entry that
        // the decoder takes directly is never stored.
        push_ok = bus.valid_from_fetcher & ~full & ~bypass_take;
        pop_ok  = bus.pop_from_decoder & ~empty;

        if (push_ok) tail_d = tail_q + ptr_t'(1);
        if (pop_ok)  head_d = head_q + ptr_t'(1);

        count_d = count_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer / count registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage arrays carry no reset; count_q alone says which slots
  // hold live data, and leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[tail_q]    <= bus.pc_from_fetcher;
      instr_mem[tail_q] <= bus.instr_from_fetcher;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The head is forced to zero when empty so that stale RAM contents never
  // reach the decoder.
  always_comb begin
    bus.pc_to_decoder    = '0;
    bus.instr_to_decoder = '0;
    if (bypass_hit) begin
      bus.pc_to_decoder    = bus.pc_from_fetcher;
      bus.instr_to_decoder = bus.instr_from_fetcher;
    end else if (!empty) begin
      bus.pc_to_decoder    = pc_mem[head_q];
      bus.instr_to_decoder = instr_mem[head_q];
    end
  end

  assign bus.is_empty_to_decoder = empty & ~bypass_hit;
  assign bus.full_to_fetcher     = full;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // Occupancy never exceeds the depth.
  a_count_range : assert property (
    @(posedge clk) disable iff (rst) count_q <= cnt_t'(DEPTH)
  );

  // The pointer distance always equals the occupancy modulo the depth.
  a_ptr_count : assert property (
    @(posedge clk) disable iff (rst)
      ptr_t'(tail_q - head_q) == count_q[DEPTH_LOG2-1:0]
  );

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instr_queue_if #(.PC_W(32), .INSTR_W(32)) bus ();

  instr_queue #(.DEPTH_LOG2(4), .PC_W(32), .INSTR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: an ordered list of pending (pc, instr) entries.
  logic [31:0] m_pc [$];
  logic [31:0] m_in [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [31:0] p, input logic [31:0] i, input logic pp);
    bus.rdy                = r;
    bus.flush              = f;
    bus.valid_from_fetcher = v;
    bus.pc_from_fetcher    = p;
    bus.instr_from_fetcher = i;
    bus.pop_from_decoder   = pp;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic model_clear();
    m_pc.delete();
    m_in.delete();
  endtask

  function automatic bit model_bypass();
`ifdef IQ_BYPASS_EN
    return (m_pc.size() == 0) && bus.valid_from_fetcher && bus.rdy && !bus.flush;
`else
    return 1'b0;
`endif
  endfunction

  // Apply the queue rules for one clock edge to the model.
  task automatic model_edge();
    bit push_ok, pop_ok;
    if (!bus.rdy) return;
    if (bus.flush) begin
      model_clear();
      return;
    end
    if (model_bypass() && bus.pop_from_decoder) return;  // consumed in flight
    push_ok = bus.valid_from_fetcher && (m_pc.size() < DEPTH);
    pop_ok  = bus.pop_from_decoder && (m_pc.size() > 0);
    if (pop_ok) begin
      void'(m_pc.pop_front());
      void'(m_in.pop_front());
    end
    if (push_ok) begin
      m_pc.push_back(bus.pc_from_fetcher);
      m_in.push_back(bus.instr_from_fetcher);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] ep, ei;
    logic        ee;
    if (model_bypass()) begin
      ee = 1'b0; ep = bus.pc_from_fetcher; ei = bus.instr_from_fetcher;
    end else if (m_pc.size() > 0) begin
      ee = 1'b0; ep = m_pc[0]; ei = m_in[0];
    end else begin
      ee = 1'b1; ep = 32'h0; ei = 32'h0;
    end
    check({tag, ".empty"}, {31'b0, bus.is_empty_to_decoder}, {31'b0, ee});
    check({tag, ".full"},  {31'b0, bus.full_to_fetcher}, {31'b0, (m_pc.size() == DEPTH)});
    check({tag, ".pc"},    bus.pc_to_decoder, ep);
    check({tag, ".instr"}, bus.instr_to_decoder, ei);
  endtask

  // Inputs are already driven: check the combinational view, take the edge,
  // return inputs to idle and check the registered result.
  task automatic step(input string tag);
    #1 check_outputs({tag, ".pre"});
    @(posedge clk);
    model_edge();
    #1 idle();
    #1 check_outputs(tag);
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input string tag);
    drive(1'b1, 1'b0, 1'b1, p, i, 1'b0);
    step(tag);
  endtask

  task automatic pop(input string tag);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(tag);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (m_pc.size() == 0) break;
      pop(tag);
    end
  endtask

  typedef struct {
    logic        rdy, flush, valid;
    logic [31:0] pc, instr;
    logic        pop;
    logic        e_empty, e_full;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic v, logic [31:0] p, logic [31:0] i,
                              logic pp, logic ee, logic ef, logic [31:0] ep, logic [31:0] ei);
    vec_t t;
    t.rdy = r; t.flush = f; t.valid = v; t.pc = p; t.instr = i; t.pop = pp;
    t.e_empty = ee; t.e_full = ef; t.e_pc = ep; t.e_instr = ei;
    return t;
  endfunction

  vec_t vecs [12];

  initial begin
    //        rdy fl  vld pc          instr         pop  empty full pc          instr
    vecs[0]  = mk(1, 0, 1, 32'h1000, 32'h00500093, 0,   0, 0, 32'h1000, 32'h00500093);
    vecs[1]  = mk(1, 0, 1, 32'h1004, 32'h00a00113, 1,   0, 0, 32'h1004, 32'h00a00113);
    vecs[2]  = mk(1, 0, 0, 32'h0,    32'h0,        1,   1, 0, 32'h0,    32'h0);
    vecs[3]  = mk(1, 0, 0, 32'h0,    32'h0,        1,   1, 0, 32'h0,    32'h0);
    vecs[4]  = mk(0, 0, 1, 32'h1008, 32'h11,       0,   1, 0, 32'h0,    32'h0);
    vecs[5]  = mk(1, 1, 1, 32'h100c, 32'h22,       0,   1, 0, 32'h0,    32'h0);
    vecs[6]  = mk(1, 0, 1, 32'h1010, 32'h33,       0,   0, 0, 32'h1010, 32'h33);
    vecs[7]  = mk(1, 0, 1, 32'h1014, 32'h44,       0,   0, 0, 32'h1010, 32'h33);
    vecs[8]  = mk(1, 1, 0, 32'h0,    32'h0,        1,   1, 0, 32'h0,    32'h0);
    vecs[9]  = mk(1, 0, 1, 32'h2000, 32'h55,       0,   0, 0, 32'h2000, 32'h55);
    vecs[10] = mk(0, 0, 0, 32'h0,    32'h0,        1,   0, 0, 32'h2000, 32'h55);
    vecs[11] = mk(1, 0, 0, 32'h0,    32'h0,        1,   1, 0, 32'h0,    32'h0);

    idle();
    #1 check("rst.empty", {31'b0, bus.is_empty_to_decoder}, 32'h1);
    check("rst.full", {31'b0, bus.full_to_fetcher}, 32'h0);
    #11 rst = 1'b0;  // released mid-cycle (t=12)

    // Async reset mid-operation with rdy low: clears without a clock edge.
    push(32'hAAA0, 32'h1, "pre_rst");
    push(32'hAAA4, 32'h2, "pre_rst");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    check("arst1.empty", {31'b0, bus.is_empty_to_decoder}, 32'h1);
    check("arst1.full",  {31'b0, bus.full_to_fetcher}, 32'h0);
    check("arst1.pc",    bus.pc_to_decoder, 32'h0);
    check("arst1.instr", bus.instr_to_decoder, 32'h0);
    model_clear();
    rst = 1'b0;
    idle();

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rdy, vecs[i].flush, vecs[i].valid, vecs[i].pc, vecs[i].instr, vecs[i].pop);
      @(posedge clk);
      model_edge();
      #1 idle();
      #1;
      check($sformatf("vec%0d.empty", i), {31'b0, bus.is_empty_to_decoder}, {31'b0, vecs[i].e_empty});
      check($sformatf("vec%0d.full", i),  {31'b0, bus.full_to_fetcher},     {31'b0, vecs[i].e_full});
      check($sformatf("vec%0d.pc", i),    bus.pc_to_decoder,    vecs[i].e_pc);
      check($sformatf("vec%0d.instr", i), bus.instr_to_decoder, vecs[i].e_instr);
    end

    // Fill and overflow: 17 pushes, the last one dropped.
    for (int i = 0; i < 17; i++) begin
      push(32'(4 * i), 32'h100 + 32'(i), "fill");
      if (i == 14) check("fill.not_full15", {31'b0, bus.full_to_fetcher}, 32'h0);
      if (i == 15) check("fill.full16", {31'b0, bus.full_to_fetcher}, 32'h1);
    end
    // Push while full with a simultaneous pop is still dropped.
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
    step("full_pushpop");
    check("full_pushpop.head", bus.pc_to_decoder, 32'h4);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain%0d.pc", i), bus.pc_to_decoder, 32'(4 * i));
      pop("drain");
    end
    check("drain.empty", {31'b0, bus.is_empty_to_decoder}, 32'h1);

    // Simultaneous push/pop at count 5.
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(4 * i), 32'(i), "c5");
    drive(1'b1, 1'b0, 1'b1, 32'h600, 32'h6, 1'b1);
    step("c5.pushpop");
    check("c5.head", bus.pc_to_decoder, 32'h504);
    for (int i = 0; i < 4; i++) pop("c5.drain");
    check("c5.tail", bus.pc_to_decoder, 32'h600);
    pop("c5.last");
    check("c5.empty", {31'b0, bus.is_empty_to_decoder}, 32'h1);

    // Wrap: 40 push/pop cycles with 3 entries resident.
    for (int i = 0; i < 3; i++) push(32'h7000 + 32'(4 * i), 32'(i), "wrap.fill");
    for (int i = 3; i < 43; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h7000 + 32'(4 * i), 32'(i), 1'b1);
      step("wrap");
    end
    check("wrap.head", bus.pc_to_decoder, 32'h7000 + 32'(4 * 40));
    drain("wrap.drain");

    // Flush at count 7 with same-cycle push and pop.
    for (int i = 0; i < 7; i++) push(32'h800 + 32'(4 * i), 32'(i), "fl");
    drive(1'b1, 1'b1, 1'b1, 32'h900, 32'h9, 1'b1);
    step("fl.flush");
    check("fl.empty", {31'b0, bus.is_empty_to_decoder}, 32'h1);
    push(32'h2000, 32'h77, "fl.push");
    check("fl.head", bus.pc_to_decoder, 32'h2000);
    drain("fl.drain");

    // rdy low for 3 cycles with push and pop held.
    for (int i = 0; i < 4; i++) push(32'hA00 + 32'(4 * i), 32'(i), "rdy");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hBAD0, 32'hBAD, 1'b1);
      step("rdy.hold");
      check("rdy.head", bus.pc_to_decoder, 32'hA00);
    end
    for (int i = 0; i < 4; i++) pop("rdy.drain");
    check("rdy.count4", {31'b0, bus.is_empty_to_decoder}, 32'h1);

    // Async reset at count 9.
    for (int i = 0; i < 9; i++) push(32'hC00 + 32'(4 * i), 32'(i), "arst");
    rst = 1'b1;
    #1;
    check("arst9.empty", {31'b0, bus.is_empty_to_decoder}, 32'h1);
    check("arst9.pc",    bus.pc_to_decoder, 32'h0);
    model_clear();
    @(posedge clk);
    #2 rst = 1'b0;
    check_outputs("arst9.post");

`ifdef IQ_BYPASS_EN
    drive(1'b1, 1'b0, 1'b1, 32'h3000, 32'h3, 1'b1);
    #1;
    check("byp.take.empty", {31'b0, bus.is_empty_to_decoder}, 32'h0);
    check("byp.take.pc",    bus.pc_to_decoder, 32'h3000);
    step("byp.take");
    check("byp.take.after", {31'b0, bus.is_empty_to_decoder}, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 32'h3004, 32'h4, 1'b0);
    #1 check("byp.keep.pc", bus.pc_to_decoder, 32'h3004);
    step("byp.keep");
    check("byp.keep.head", bus.pc_to_decoder, 32'h3004);
    drain("byp.drain");
`endif

    // Randomized traffic in phases with different fill pressure.
    for (int ph = 0; ph < 6; ph++) begin
      int pv, pp;
      pv = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 25;
      pp = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 50 : 75;
      for (int c = 0; c < 500; c++) begin
        drive($urandom_range(99) < 92,
              $urandom_range(199) == 0,
              $urandom_range(99) < pv,
              $urandom,
              $urandom,
              $urandom_range(99) < pp);
        step($sformatf("rnd%0d", ph));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
